fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 122 ++++++++++++
 tb/tb_fetch_queue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: PC-owning fetch stage with circular instruction queue, JAL/branch redirect, JALR stall, rollback; `FETCH_BHT_EN adds a 2-bit BHT
module fetch_queue #(
  parameter int QUEUE_DEPTH = 8,
  parameter int BHT_IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic [31:0] rollback_pc,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_data,
  output logic        inst_rdy,
  output logic [31:0] inst,
  output logic [31:0] inst_PC,
  output logic        inst_is_Jump,
  input  logic        dec_take,
  input  logic        JALR_pause_rej,
  input  logic [31:0] JALR_PC,
  input  logic        bp_upd_en,
  input  logic [31:0] bp_upd_pc,
  input  logic        bp_upd_taken
);
  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam logic [QW:0] DEPTH = (QW+1)'(QUEUE_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, JALR_WAIT = 2'd2, DISCARD = 2'd3;
  localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_BR = 7'b1100011;
  logic [1:0] state_q, state_d;
  logic [31:0] pc_q, pc_d, mc_addr_q, mc_addr_d;
  logic mc_req_q, mc_req_d;
  logic [QW-1:0] head_q, head_d, tail_q, tail_d;
  logic [QW:0] count_q, count_d;
  logic [64:0] q_mem [QUEUE_DEPTH];
  logic push, pop, taken, pred, br_taken, unused_bp;
  logic [6:0] op;
  logic [31:0] imm_j, imm_b, npc;
`ifdef FETCH_BHT_EN
  logic [1:0] bht_q [2**BHT_IDX_W];
  logic [BHT_IDX_W-1:0] upd_idx;
  logic [1:0] upd_cnt, upd_nxt;
  assign taken = bht_q[pc_q[BHT_IDX_W+1:2]][1];
  assign upd_idx = bp_upd_pc[BHT_IDX_W+1:2];
  assign upd_cnt = bht_q[upd_idx];
  assign upd_nxt = bp_upd_taken ? (upd_cnt == 2'b11 ? upd_cnt : upd_cnt + 2'd1)
                                : (upd_cnt == 2'b00 ? upd_cnt : upd_cnt - 2'd1);
  assign unused_bp = &{1'b0, bp_upd_pc[31:BHT_IDX_W+2], bp_upd_pc[1:0]};
  always_ff @(posedge clk)
    if (rst) bht_q <= '{default: 2'b01};
    else if (rdy && bp_upd_en) bht_q[upd_idx] <= upd_nxt;
`else
  assign taken = 1'b0;
  assign unused_bp = &{1'b0, bp_upd_en, bp_upd_pc, bp_upd_taken};
`endif
  assign op = mc_data[6:0];
  assign imm_j = {{12{mc_data[31]}}, mc_data[19:12], mc_data[20], mc_data[30:21], 1'b0};
  assign imm_b = {{20{mc_data[31]}}, mc_data[7], mc_data[30:25], mc_data[11:8], 1'b0};
  assign br_taken = op == OP_BR && taken;
  assign pred = op == OP_JAL || br_taken;
  assign npc = pc_q + (op == OP_JAL ? imm_j : br_taken ? imm_b : 32'd4);
  assign push = state_q == FETCH && mc_done && !rollback;
  assign pop = inst_rdy && dec_take;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    mc_req_d = mc_req_q;
    mc_addr_d = mc_addr_q;
    case (state_q)
      IDLE: if (count_q < DEPTH) begin
        state_d = FETCH;
        mc_req_d = 1'b1;
        mc_addr_d = pc_q;
      end
      FETCH: if (mc_done) begin
        mc_req_d = 1'b0;
        pc_d = npc;
        state_d = op == OP_JALR ? JALR_WAIT : IDLE;
      end
      JALR_WAIT: if (JALR_pause_rej) begin
        pc_d = JALR_PC;
        state_d = IDLE;
      end
      default: state_d = mc_done ? IDLE : DISCARD;
    endcase
    head_d = head_q + QW'(pop);
    tail_d = tail_q + QW'(push);
    count_d = count_q + (QW+1)'(push) - (QW+1)'(pop);
    if (rollback) begin
      pc_d = rollback_pc;
      mc_req_d = 1'b0;
      head_d = '0;
      tail_d = '0;
      count_d = '0;
      state_d = state_q == DISCARD ? state_d : state_q == FETCH && !mc_done ? DISCARD : IDLE;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      pc_q <= '0;
      mc_req_q <= 1'b0;
      mc_addr_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      pc_q <= pc_d;
      mc_req_q <= mc_req_d;
      mc_addr_q <= mc_addr_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk)
    if (!rst && rdy && push) q_mem[tail_q] <= {mc_data, pc_q, pred};
  assign mc_req = mc_req_q;
  assign mc_addr = mc_addr_q;
  assign inst_rdy = |count_q;
  assign {inst, inst_PC, inst_is_Jump} = q_mem[head_q];
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst, rdy, rollback, mc_done, dec_take, JALR_pause_rej, bp_upd_en, bp_upd_taken;
  logic [31:0] rollback_pc, mc_data, JALR_PC, bp_upd_pc;
  logic mc_req, inst_rdy, inst_is_Jump;
  logic [31:0] mc_addr, inst, inst_PC;
  int checks = 0;
  int errors = 0;
  localparam logic [31:0] NOP = 32'h00100093, JAL16 = 32'h010000EF, JAL32 = 32'h020000EF;
  localparam logic [31:0] BNE_M8 = 32'hFE009CE3, JALR = 32'h00008067;
`ifdef FETCH_BHT_EN
  localparam logic [31:0] BR_ADDR = 32'h18;
  localparam logic BR_J = 1'b1;
`else
  localparam logic [31:0] BR_ADDR = 32'h24;
  localparam logic BR_J = 1'b0;
`endif
  always #5 clk = ~clk;
  fetch_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .rollback_pc(rollback_pc),
    .mc_req(mc_req), .mc_addr(mc_addr), .mc_done(mc_done), .mc_data(mc_data),
    .inst_rdy(inst_rdy), .inst(inst), .inst_PC(inst_PC), .inst_is_Jump(inst_is_Jump),
    .dec_take(dec_take), .JALR_pause_rej(JALR_pause_rej), .JALR_PC(JALR_PC),
    .bp_upd_en(bp_upd_en), .bp_upd_pc(bp_upd_pc), .bp_upd_taken(bp_upd_taken)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rdy = 1'b1;
    rollback = 1'b0;
    rollback_pc = '0;
    mc_done = 1'b0;
    mc_data = '0;
    dec_take = 1'b0;
    JALR_pause_rej = 1'b0;
    JALR_PC = '0;
    bp_upd_en = 1'b0;
    bp_upd_pc = '0;
    bp_upd_taken = 1'b0;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask
  task automatic wait_req(input string name);
    int n = 0;
    while (!mc_req && n < 20) begin
      tick;
      n++;
    end
    checks++;
    if (mc_req !== 1'b1) begin
      errors++;
      $display("FAIL %s: mc_req=%b after %0d cycles, required 1", name, mc_req, n);
    end
  endtask
  task automatic respond(input logic [31:0] d);
    mc_data = d;
    mc_done = 1'b1;
    tick;
    mc_done = 1'b0;
  endtask
  task automatic test_reset;
    do_reset;
    rst = 1'b1;
    tick;
    checks++;
    if (mc_req !== 1'b0) begin errors++; $display("FAIL reset_req: mc_req=%b required 0", mc_req); end
    checks++;
    if (mc_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: mc_addr=%h required 0", mc_addr); end
    checks++;
    if (inst_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: inst_rdy=%b required 0", inst_rdy); end
    rst = 1'b0;
  endtask
  task automatic test_straight;
    do_reset;
    dec_take = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_req("straight_req");
      checks++;
      if (mc_addr !== 32'(4 * i)) begin errors++; $display("FAIL straight_addr: mc_addr=%h required %h", mc_addr, 32'(4 * i)); end
      respond(NOP);
      checks++;
      if (inst_rdy !== 1'b1 || inst_PC !== 32'(4 * i)) begin
        errors++;
        $display("FAIL straight_pc: inst_rdy=%b inst_PC=%h required 1 %h", inst_rdy, inst_PC, 32'(4 * i));
      end
      checks++;
      if (inst_is_Jump !== 1'b0) begin errors++; $display("FAIL straight_jump: inst_is_Jump=%b required 0", inst_is_Jump); end
    end
  endtask
  task automatic test_jal;
    do_reset;
    dec_take = 1'b1;
    wait_req("jal_req0");
    respond(JAL16);
    checks++;
    if (inst_PC !== 32'h0 || inst_is_Jump !== 1'b1 || inst !== JAL16) begin
      errors++;
      $display("FAIL jal_entry: inst=%h pc=%h jump=%b required %h 0 1", inst, inst_PC, inst_is_Jump, JAL16);
    end
    wait_req("jal_req1");
    checks++;
    if (mc_addr !== 32'h10) begin errors++; $display("FAIL jal_addr: mc_addr=%h required 00000010", mc_addr); end
  endtask
  task automatic test_bht;
    do_reset;
    dec_take = 1'b1;
    bp_upd_pc = 32'h20;
    bp_upd_taken = 1'b1;
    bp_upd_en = 1'b1;
    repeat (3) tick;
    bp_upd_en = 1'b0;
    wait_req("bht_req0");
    respond(JAL32);
    wait_req("bht_req1");
    checks++;
    if (mc_addr !== 32'h20) begin errors++; $display("FAIL bht_jal_addr: mc_addr=%h required 00000020", mc_addr); end
    respond(BNE_M8);
    checks++;
    if (inst_PC !== 32'h20 || inst_is_Jump !== BR_J) begin
      errors++;
      $display("FAIL bht_pred: inst_PC=%h jump=%b required 00000020 %b", inst_PC, inst_is_Jump, BR_J);
    end
    wait_req("bht_req2");
    checks++;
    if (mc_addr !== BR_ADDR) begin errors++; $display("FAIL bht_addr: mc_addr=%h required %h", mc_addr, BR_ADDR); end
    bp_upd_taken = 1'b0;
    bp_upd_en = 1'b1;
    repeat (2) tick;
    bp_upd_en = 1'b0;
    rollback_pc = 32'h20;
    rollback = 1'b1;
    tick;
    rollback = 1'b0;
    respond(JAL16);
    wait_req("bht_req3");
    checks++;
    if (mc_addr !== 32'h20) begin errors++; $display("FAIL bht_refetch: mc_addr=%h required 00000020", mc_addr); end
    respond(BNE_M8);
    checks++;
    if (inst_is_Jump !== 1'b0) begin errors++; $display("FAIL bht_untrained: inst_is_Jump=%b required 0", inst_is_Jump); end
    wait_req("bht_req4");
    checks++;
    if (mc_addr !== 32'h24) begin errors++; $display("FAIL bht_nt_addr: mc_addr=%h required 00000024", mc_addr); end
  endtask
  task automatic test_jalr;
    do_reset;
    dec_take = 1'b1;
    repeat (2) begin
      wait_req("jalr_pre");
      respond(NOP);
    end
    wait_req("jalr_req");
    checks++;
    if (mc_addr !== 32'h8) begin errors++; $display("FAIL jalr_addr: mc_addr=%h required 00000008", mc_addr); end
    respond(JALR);
    checks++;
    if (inst_PC !== 32'h8 || inst_is_Jump !== 1'b0) begin
      errors++;
      $display("FAIL jalr_entry: inst_PC=%h jump=%b required 00000008 0", inst_PC, inst_is_Jump);
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (mc_req !== 1'b0) begin errors++; $display("FAIL jalr_stall: cycle %0d mc_req=%b required 0", i, mc_req); end
    end
    JALR_PC = 32'h100;
    JALR_pause_rej = 1'b1;
    tick;
    JALR_pause_rej = 1'b0;
    wait_req("jalr_resume");
    checks++;
    if (mc_addr !== 32'h100) begin errors++; $display("FAIL jalr_target: mc_addr=%h required 00000100", mc_addr); end
  endtask
  task automatic test_rollback;
    do_reset;
    wait_req("rb_req0");
    respond(NOP);
    checks++;
    if (inst_rdy !== 1'b1) begin errors++; $display("FAIL rb_queued: inst_rdy=%b required 1", inst_rdy); end
    wait_req("rb_req1");
    rollback_pc = 32'h40;
    rollback = 1'b1;
    tick;
    rollback = 1'b0;
    checks++;
    if (inst_rdy !== 1'b0) begin errors++; $display("FAIL rb_flush: inst_rdy=%b required 0", inst_rdy); end
    checks++;
    if (mc_req !== 1'b0) begin errors++; $display("FAIL rb_req_drop: mc_req=%b required 0", mc_req); end
    tick;
    respond(JAL16);
    checks++;
    if (inst_rdy !== 1'b0) begin errors++; $display("FAIL rb_late_data: inst_rdy=%b required 0", inst_rdy); end
    wait_req("rb_req2");
    checks++;
    if (mc_addr !== 32'h40) begin errors++; $display("FAIL rb_addr: mc_addr=%h required 00000040", mc_addr); end
    respond(NOP);
    checks++;
    if (inst_rdy !== 1'b1 || inst_PC !== 32'h40) begin
      errors++;
      $display("FAIL rb_entry: inst_rdy=%b inst_PC=%h required 1 00000040", inst_rdy, inst_PC);
    end
  endtask
  task automatic test_rdy;
    do_reset;
    wait_req("rdy_req");
    rdy = 1'b0;
    respond(NOP);
    tick;
    checks++;
    if (inst_rdy !== 1'b0 || mc_req !== 1'b1) begin
      errors++;
      $display("FAIL rdy_hold: inst_rdy=%b mc_req=%b required 0 1", inst_rdy, mc_req);
    end
    rdy = 1'b1;
    respond(NOP);
    checks++;
    if (inst_rdy !== 1'b1 || inst_PC !== 32'h0) begin
      errors++;
      $display("FAIL rdy_resume: inst_rdy=%b inst_PC=%h required 1 00000000", inst_rdy, inst_PC);
    end
  endtask
  task automatic test_backpressure;
    do_reset;
    for (int i = 0; i < 8; i++) begin
      wait_req("bp_fill");
      respond(NOP);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (mc_req !== 1'b0) begin errors++; $display("FAIL bp_full_req: cycle %0d mc_req=%b required 0", i, mc_req); end
    end
    checks++;
    if (inst_PC !== 32'h0) begin errors++; $display("FAIL bp_head: inst_PC=%h required 00000000", inst_PC); end
    dec_take = 1'b1;
    tick;
    dec_take = 1'b0;
    checks++;
    if (inst_PC !== 32'h4) begin errors++; $display("FAIL bp_pop: inst_PC=%h required 00000004", inst_PC); end
    wait_req("bp_refill");
    checks++;
    if (mc_addr !== 32'h20) begin errors++; $display("FAIL bp_refill_addr: mc_addr=%h required 00000020", mc_addr); end
    respond(NOP);
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (mc_req !== 1'b0) begin errors++; $display("FAIL bp_one_req: cycle %0d mc_req=%b required 0", i, mc_req); end
    end
    dec_take = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (inst_rdy !== 1'b1 || inst_PC !== 32'(4 * (i + 1))) begin
        errors++;
        $display("FAIL bp_drain: entry %0d inst_rdy=%b inst_PC=%h required 1 %h", i, inst_rdy, inst_PC, 32'(4 * (i + 1)));
      end
      tick;
    end
    dec_take = 1'b0;
    checks++;
    if (inst_rdy !== 1'b0) begin errors++; $display("FAIL bp_empty: inst_rdy=%b required 0", inst_rdy); end
  endtask
  initial begin
    test_reset;
    test_straight;
    test_jal;
    test_bht;
    test_jalr;
    test_rollback;
    test_rdy;
    test_backpressure;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
